weight_fetch_scheduler: RTL and testbench

Sequences the weight memory controller over a full layer. Walks output-depth pairs (od1, od1+1) in the outer loop and input-depth slices in the inner loop, and issues one request per (od pair, id slice). It waits for the returned tile(s) before issuing the next request and throttles on PE-array readiness. It sits between the main layer controller and the weight memory controller's request inputs (total_od, weight_od1, weight_id, weight_main_valid).

---
 rtl/weight_fetch_scheduler.sv | 158 +++++++++++++++
 tb/tb_weight_fetch_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_scheduler.sv
// Walks (od pair, id slice) weight requests for one layer; optional WAIT watchdog under WEIGHT_SCHED_TIMEOUT_EN.
// Latency: request strobe in ISSUE cycle when pe_ready_i; ack/next request one cycle after tiles complete. Backpressure: holds in ISSUE while !pe_ready_i.
module weight_fetch_scheduler #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] total_od_cfg_i,
  input  logic [3:0] total_id_cfg_i,
  input  logic       pe_ready_i,
  input  logic       weight_valid_1_i,
  input  logic       weight_valid_2_i,
  output logic [7:0] total_od_o,
  output logic [7:0] weight_od1_o,
  output logic [3:0] weight_id_o,
  output logic       weight_main_valid_o,
  output logic       tile_ack_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] total_od_q, total_od_d, od1_q, od1_d;
  logic [3:0] total_id_q, total_id_d, id_q, id_d;
  logic       got1_q, got1_d, got2_q, got2_d;
  logic       ack_q, ack_d, err_q, err_d;
  logic       strobe, have1, have2, last_pair, id_wrap, last_req, complete, timeout;
  logic [8:0] od1_next;

  assign strobe    = (state_q == S_ISSUE) && pe_ready_i;
  assign have1     = got1_q | weight_valid_1_i;
  assign have2     = got2_q | weight_valid_2_i;
  // Odd total_od: the final pair has no second channel, so only tile 1 is required.
  assign last_pair = (({1'b0, od1_q} + 9'd1) == {1'b0, total_od_q});
  assign complete  = (state_q == S_WAIT) && have1 && (have2 || last_pair);
  assign id_wrap   = (id_q == (total_id_q - 4'd1));
  assign od1_next  = {1'b0, od1_q} + 9'd2;
  assign last_req  = (od1_next >= {1'b0, total_od_q}) && id_wrap;

`ifdef WEIGHT_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count includes the strobe cycle, so err_o rises TIMEOUT_CYCLES after the strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (strobe) begin
      cnt_d = CNT_W'(1);
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (state_q == S_WAIT) && !complete && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    total_od_d = total_od_q;
    total_id_d = total_id_q;
    od1_d      = od1_q;
    id_d       = id_q;
    got1_d     = got1_q;
    got2_d     = got2_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          total_od_d = total_od_cfg_i;
          total_id_d = total_id_cfg_i;
          err_d      = 1'b0;
          if ((total_od_cfg_i == 8'd0) || (total_id_cfg_i == 4'd0)) begin
            state_d = S_DONE;
          end else begin
            od1_d   = 8'd0;
            id_d    = 4'd0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (pe_ready_i) begin
          got1_d  = 1'b0;
          got2_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        got1_d = have1;
        got2_d = have2;
        if (complete) begin
          ack_d = 1'b1;
          if (id_wrap) begin
            id_d  = 4'd0;
            od1_d = od1_next[7:0];
          end else begin
            id_d = id_q + 4'd1;
          end
          state_d = last_req ? S_DONE : S_ISSUE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      total_od_q <= 8'd0;
      total_id_q <= 4'd0;
      od1_q      <= 8'd0;
      id_q       <= 4'd0;
      got1_q     <= 1'b0;
      got2_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_od_q <= total_od_d;
      total_id_q <= total_id_d;
      od1_q      <= od1_d;
      id_q       <= id_d;
      got1_q     <= got1_d;
      got2_q     <= got2_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign total_od_o          = total_od_q;
  assign weight_od1_o        = od1_q;
  assign weight_id_o         = id_q;
  assign weight_main_valid_o = strobe;
  assign tile_ack_o          = ack_q;
  assign busy_o              = (state_q != S_IDLE);
  assign done_o              = (state_q == S_DONE);
  assign err_o               = err_q;

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Scoreboard bench for weight_fetch_scheduler: expected (od1,id,total_od) requests queued at start, popped on strobes.
module tb_weight_fetch_scheduler;

  logic       clk;
  logic       reset;
  logic       start_i;
  logic [7:0] total_od_cfg_i;
  logic [3:0] total_id_cfg_i;
  logic       pe_ready_i;
  logic       weight_valid_1_i;
  logic       weight_valid_2_i;
  logic [7:0] total_od_o;
  logic [7:0] weight_od1_o;
  logic [3:0] weight_id_o;
  logic       weight_main_valid_o;
  logic       tile_ack_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  typedef struct {
    logic [7:0] od1;
    logic [3:0] id;
    logic [7:0] tod;
  } req_t;

  req_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   ack_cnt = 0;
  int   done_cnt = 0;

  weight_fetch_scheduler #(.TIMEOUT_CYCLES(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start_i             (start_i),
    .total_od_cfg_i      (total_od_cfg_i),
    .total_id_cfg_i      (total_id_cfg_i),
    .pe_ready_i          (pe_ready_i),
    .weight_valid_1_i    (weight_valid_1_i),
    .weight_valid_2_i    (weight_valid_2_i),
    .total_od_o          (total_od_o),
    .weight_od1_o        (weight_od1_o),
    .weight_id_o         (weight_id_o),
    .weight_main_valid_o (weight_main_valid_o),
    .tile_ack_o          (tile_ack_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .err_o               (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: every request must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset) begin
      if (weight_main_valid_o === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_strobe: got od1=%0d id=%0d, expected no request", weight_od1_o, weight_id_o);
        end else begin
          req_t e;
          e = exp_q.pop_front();
          if (weight_od1_o !== e.od1 || weight_id_o !== e.id || total_od_o !== e.tod) begin
            n_bad++;
            $display("FAIL strobe_fields: got od1=%0d id=%0d tod=%0d, expected od1=%0d id=%0d tod=%0d",
                     weight_od1_o, weight_id_o, total_od_o, e.od1, e.id, e.tod);
          end
        end
      end
      if (tile_ack_o === 1'b1) ack_cnt++;
      if (done_o === 1'b1) done_cnt++;
    end
  end

  task automatic push_layer(input int tod, input int tid);
    req_t r;
    for (int o = 0; o < tod; o += 2) begin
      for (int i = 0; i < tid; i++) begin
        r.od1 = 8'(o);
        r.id  = 4'(i);
        r.tod = 8'(tod);
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic start_layer(input int tod, input int tid);
    @(posedge clk); #1;
    start_i        = 1'b1;
    total_od_cfg_i = 8'(tod);
    total_id_cfg_i = 4'(tid);
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_strobe(output int lat);
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (weight_main_valid_o === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Waits for a strobe, then returns tile 1 / tile 2 d1 / d2 cycles after it.
  task automatic serve(input int d1, input int d2, input bit skip2, output int lat);
    int last;
    wait_strobe(lat);
    n_vec++;
    if (lat == 0) begin
      n_bad++;
      $display("FAIL strobe_wait: got no strobe in 100 cycles, expected one");
    end else begin
      last = (d1 > d2 || skip2) ? d1 : d2;
      for (int j = 1; j <= last; j++) begin
        @(posedge clk); #1;
        weight_valid_1_i = (j == d1);
        weight_valid_2_i = (j == d2) && !skip2;
      end
      @(posedge clk); #1;
      weight_valid_1_i = 1'b0;
      weight_valid_2_i = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy_o, weight_main_valid_o, tile_ack_o, done_o, err_o, total_od_o, weight_od1_o, weight_id_o} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b od1=%0d id=%0d tod=%0d, expected all 0", busy_o, weight_od1_o, weight_id_o, total_od_o);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy_o, weight_main_valid_o, tile_ack_o, done_o, err_o} !== 5'd0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b valid=%b, expected 0", busy_o, weight_main_valid_o);
    end
  endtask

  task automatic test_basic;
    int a0, d0, lat;
    a0 = ack_cnt; d0 = done_cnt;
    pe_ready_i = 1'b1;
    push_layer(4, 2);
    start_layer(4, 2);
    for (int r = 0; r < 4; r++) begin
      serve(3, 3, 1'b0, lat);
      n_vec++;
      if (lat !== 1) begin
        n_bad++;
        $display("FAIL basic_latency[%0d]: got %0d, expected 1", r, lat);
      end
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (ack_cnt - a0 !== 4 || done_cnt - d0 !== 1 || exp_q.size() !== 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_totals: got acks=%0d dones=%0d left=%0d busy=%b, expected 4 1 0 0",
               ack_cnt - a0, done_cnt - d0, exp_q.size(), busy_o);
    end
  endtask

  task automatic test_odd_od;
    int a0, d0, lat;
    a0 = ack_cnt; d0 = done_cnt;
    push_layer(3, 1);
    start_layer(3, 1);
    serve(2, 2, 1'b0, lat);
    serve(2, 2, 1'b1, lat);
    n_vec++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL odd_latency: got %0d, expected 1", lat);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (ack_cnt - a0 !== 2 || done_cnt - d0 !== 1 || exp_q.size() !== 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL odd_totals: got acks=%0d dones=%0d left=%0d busy=%b, expected 2 1 0 0",
               ack_cnt - a0, done_cnt - d0, exp_q.size(), busy_o);
    end
  endtask

  task automatic test_split_valid;
    int a0, d0, lat;
    a0 = ack_cnt; d0 = done_cnt;
    push_layer(2, 1);
    start_layer(2, 1);
    wait_strobe(lat);
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      weight_valid_1_i = (j == 2);
      weight_valid_2_i = (j == 5);
    end
    @(negedge clk);
    n_vec++;
    if (tile_ack_o !== 1'b0) begin
      n_bad++;
      $display("FAIL split_ack_early: got %b at strobe+5, expected 0", tile_ack_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (tile_ack_o !== 1'b1 || done_o !== 1'b1) begin
      n_bad++;
      $display("FAIL split_ack: got ack=%b done=%b at strobe+6, expected 1 1", tile_ack_o, done_o);
    end
    repeat (3) begin
      @(posedge clk); #1;
      weight_valid_2_i = ~weight_valid_2_i;
    end
    @(posedge clk); #1;
    weight_valid_2_i = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (ack_cnt - a0 !== 1 || done_cnt - d0 !== 1 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL split_late_valid: got acks=%0d dones=%0d busy=%b, expected 1 1 0", ack_cnt - a0, done_cnt - d0, busy_o);
    end
  endtask

  task automatic test_pe_stall;
    int a0, d0, lat;
    a0 = ack_cnt; d0 = done_cnt;
    push_layer(4, 1);
    start_layer(4, 1);
    wait_strobe(lat);
    @(posedge clk); #1;
    weight_valid_1_i = 1'b1;
    weight_valid_2_i = 1'b1;
    pe_ready_i       = 1'b0;
    @(posedge clk); #1;
    weight_valid_1_i = 1'b0;
    weight_valid_2_i = 1'b0;
    total_od_cfg_i   = 8'd8;
    total_id_cfg_i   = 4'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (weight_main_valid_o !== 1'b0 || busy_o !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_cycle[%0d]: got valid=%b busy=%b, expected 0 1", i, weight_main_valid_o, busy_o);
      end
      @(posedge clk); #1;
      start_i = (i == 4);
    end
    start_i    = 1'b0;
    pe_ready_i = 1'b1;
    serve(1, 1, 1'b0, lat);
    n_vec++;
    if (lat !== 1) begin
      n_bad++;
      $display("FAIL stall_release: got latency %0d, expected 1", lat);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (ack_cnt - a0 !== 2 || done_cnt - d0 !== 1 || exp_q.size() !== 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_totals: got acks=%0d dones=%0d left=%0d busy=%b, expected 2 1 0 0",
               ack_cnt - a0, done_cnt - d0, exp_q.size(), busy_o);
    end
  endtask

  task automatic test_zero_cfg;
    start_layer(5, 0);
    @(negedge clk);
    n_vec++;
    if (done_o !== 1'b1 || busy_o !== 1'b1 || total_od_o !== 8'd5) begin
      n_bad++;
      $display("FAIL zero_done: got done=%b busy=%b tod=%0d, expected 1 1 5", done_o, busy_o, total_od_o);
    end
    @(negedge clk);
    n_vec++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_after: got done=%b busy=%b, expected 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_reset_mid;
    int a0, d0, lat;
    a0 = ack_cnt; d0 = done_cnt;
    push_layer(2, 1);
    start_layer(2, 1);
    wait_strobe(lat);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, weight_main_valid_o, tile_ack_o, done_o, err_o, total_od_o, weight_od1_o, weight_id_o} !== 29'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b tod=%0d, expected all 0", busy_o, total_od_o);
    end
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    weight_valid_1_i = 1'b1;
    weight_valid_2_i = 1'b1;
    @(posedge clk); #1;
    weight_valid_1_i = 1'b0;
    weight_valid_2_i = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (ack_cnt - a0 !== 0 || done_cnt - d0 !== 0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_late_valid: got acks=%0d dones=%0d busy=%b, expected 0 0 0", ack_cnt - a0, done_cnt - d0, busy_o);
    end
  endtask

`ifdef WEIGHT_SCHED_TIMEOUT_EN
  task automatic test_timeout;
    int a0, d0, lat;
    a0 = ack_cnt; d0 = done_cnt;
    push_layer(2, 1);
    start_layer(2, 1);
    wait_strobe(lat);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (err_o !== (k >= 8)) begin
        n_bad++;
        $display("FAIL timeout_err[%0d]: got %b, expected %b", k, err_o, (k >= 8));
      end
    end
    n_vec++;
    if (busy_o !== 1'b0 || ack_cnt - a0 !== 0 || done_cnt - d0 !== 0) begin
      n_bad++;
      $display("FAIL timeout_state: got busy=%b acks=%0d dones=%0d, expected 0 0 0", busy_o, ack_cnt - a0, done_cnt - d0);
    end
    start_layer(2, 0);
    @(negedge clk);
    n_vec++;
    if (err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear: got err=%b, expected 0", err_o);
    end
  endtask
`endif

  initial begin
    reset            = 1'b0;
    start_i          = 1'b0;
    total_od_cfg_i   = 8'd0;
    total_id_cfg_i   = 4'd0;
    pe_ready_i       = 1'b0;
    weight_valid_1_i = 1'b0;
    weight_valid_2_i = 1'b0;
    test_reset();
    test_basic();
    test_odd_od();
    test_split_valid();
    test_pe_stall();
    test_zero_cfg();
    test_reset_mid();
`ifdef WEIGHT_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
